// File: rtl/bidir_pio_pkg.sv
// ---------------------------------------------------------------------------
// bidir_pio_pkg
// Shared constants for the bidirectional PIO block.
//   - Register map offsets on the 3-bit slave address bus
//   - Edge-type encodings used by the EDGE_TYPE parameter
// ---------------------------------------------------------------------------
package bidir_pio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/bidir_pio_edge_sync.sv
// ---------------------------------------------------------------------------
// pio_sync_edge
// Two-stage input synchroniser plus a delayed copy for edge detection.
// Edge pulses are suppressed until the arm counter saturates so that the
// pipeline filling up after reset never looks like a real pin edge.
// Ports:
//   clk          - sole clock
//   reset        - synchronous, active-high
//   pin_i        - raw (asynchronous) pin values
//   sync_o       - synchronised pin values (second flop stage)
//   edge_pulse_o - one-cycle pulse per bit on the selected edge type
// ---------------------------------------------------------------------------
module pio_sync_edge
   import bidir_pio_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int EDGE_TYPE = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edge_pulse_o
);

   logic [WIDTH-1:0] s1_q;
   logic [WIDTH-1:0] s2_q;
   logic [WIDTH-1:0] prev_q;
   logic [1:0]       armCnt_q;
   logic [1:0]       armCnt_d;
   logic [WIDTH-1:0] rawEdge;

   // Arm counter counts the first three clocks after reset and then holds.
   always_comb begin
      armCnt_d = (armCnt_q == 2'd3) ? 2'd3 : armCnt_q + 2'd1;
   end

   // Synchroniser chain; prev holds the previous synchronised value so an
   // edge is seen as a difference between s2 and prev.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         prev_q   <= '0;
         armCnt_q <= 2'd0;
      end else begin
         s1_q     <= pin_i;
         s2_q     <= s1_q;
         prev_q   <= s2_q;
         armCnt_q <= armCnt_d;
      end
   end

   // Edge polarity is fixed at elaboration time.
   generate
      if (EDGE_TYPE == EDGE_FALLING) begin : gFalling
         assign rawEdge = ~s2_q & prev_q;
      end else if (EDGE_TYPE == EDGE_ANY) begin : gAny
         assign rawEdge = s2_q ^ prev_q;
      end else begin : gRising
         assign rawEdge = s2_q & ~prev_q;
      end
   endgenerate

   assign sync_o       = s2_q;
   assign edge_pulse_o = (armCnt_q == 2'd3) ? rawEdge : '0;

endmodule

// File: rtl/bidir_pio_edge.sv
// ---------------------------------------------------------------------------
// bidir_pio_edge
// WIDTH-pin bidirectional parallel I/O on an Avalon-MM slave with per-bit
// direction, optional open-drain drive, edge capture, interrupt mask and
// atomic output set/clear.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   address     - register select (DATA, DIR, IRQMASK, EDGECAP, OUTSET, OUTCLR)
//   chipselect  - slave select
//   write_n     - active-low write strobe
//   writedata   - write data
//   readdata    - registered read data, one cycle after the address
//   irq         - registered level interrupt
//   bidir_port  - the pins
// ---------------------------------------------------------------------------
module bidir_pio_edge
   import bidir_pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               OPEN_DRAIN  = 0,
   parameter int               EDGE_TYPE   = EDGE_RISING,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] readdata,
   output logic             irq,
   inout  wire  [WIDTH-1:0] bidir_port
);

   logic             wr;
   logic [WIDTH-1:0] dataOut_q,  dataOut_d;
   logic [WIDTH-1:0] dataDir_q,  dataDir_d;
   logic [WIDTH-1:0] irqMask_q,  irqMask_d;
   logic [WIDTH-1:0] edgeCap_q,  edgeCap_d;
   logic [WIDTH-1:0] readData_q, readData_d;
   logic             irq_q,      irq_d;
   logic [WIDTH-1:0] capClr;
   logic [WIDTH-1:0] syncVal;
   logic [WIDTH-1:0] edgePulse;

   assign wr = chipselect & ~write_n;

   pio_sync_edge #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) uSync (
      .clk          (clk),
      .reset        (reset),
      .pin_i        (bidir_port),
      .sync_o       (syncVal),
      .edge_pulse_o (edgePulse)
   );

   // Next-state for the register file, read mux and interrupt.
   // A fresh edge is ORed in after the write-1-to-clear so that a set
   // arriving in the same cycle as a clear is never lost.
   always_comb begin
      dataOut_d = dataOut_q;
      dataDir_d = dataDir_q;
      irqMask_d = irqMask_q;
      capClr    = '0;
      if (wr) begin
         case (address)
            ADDR_DATA:    dataOut_d = writedata;
            ADDR_DIR:     dataDir_d = writedata;
            ADDR_IRQMASK: irqMask_d = writedata;
            ADDR_EDGECAP: capClr    = writedata;
            ADDR_OUTSET:  dataOut_d = dataOut_q | writedata;
            ADDR_OUTCLR:  dataOut_d = dataOut_q & ~writedata;
            default: begin end
         endcase
      end
      edgeCap_d = (edgeCap_q & ~capClr) | edgePulse;

      case (address)
         ADDR_DATA:    readData_d = syncVal;
         ADDR_DIR:     readData_d = dataDir_q;
         ADDR_IRQMASK: readData_d = irqMask_q;
         ADDR_EDGECAP: readData_d = edgeCap_q;
         default:      readData_d = '0;
      endcase

      irq_d = |(edgeCap_q & irqMask_q);
   end

   // State registers; reset wins over any write presented in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         dataOut_q  <= RESET_VALUE;
         dataDir_q  <= '0;
         irqMask_q  <= '0;
         edgeCap_q  <= '0;
         readData_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         dataOut_q  <= dataOut_d;
         dataDir_q  <= dataDir_d;
         irqMask_q  <= irqMask_d;
         edgeCap_q  <= edgeCap_d;
         readData_q <= readData_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readData_q;
   assign irq      = irq_q;

   // Pin drivers: push-pull drives both levels when the bit is an output;
   // open-drain only ever pulls low and relies on an external pull-up.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : gDrive
         if (OPEN_DRAIN != 0) begin : gOd
            assign bidir_port[i] = (dataDir_q[i] & ~dataOut_q[i]) ? 1'b0 : 1'bz;
         end else begin : gPp
            assign bidir_port[i] = dataDir_q[i] ? dataOut_q[i] : 1'bz;
         end
      end
   endgenerate

endmodule

// File: tb/tb_bidir_pio_edge.sv
// ---------------------------------------------------------------------------
// tb_bidir_pio_edge
// Self-checking bench: a push-pull instance (RESET_VALUE = A5, rising edge)
// and an open-drain instance with a pull-up on its pins. Directed tables
// and sequences first, then randomized bus traffic against a reference
// model built from pin-sample history.
// ---------------------------------------------------------------------------
module tb_bidir_pio_edge;
   import bidir_pio_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       csA, csB, write_n;
   logic [2:0] address;
   logic [7:0] writedata;
   logic [7:0] rdA, rdB;
   logic       irqA, irqB;
   wire  [7:0] ppPins;
   wire  [7:0] odPins;
   logic [7:0] tbEn, tbVal;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic [2:0] addr;
      logic       wr;
      logic [7:0] wdata;
      logic       chkRd;
      logic [7:0] expRd;
      logic       chkPin;
      logic [7:0] expPin;
   } vec_t;

   vec_t tblReset[8];
   vec_t tblPp[8];

   // Reference model state
   logic       modelOn;
   logic [7:0] initDir, initOut;
   logic [7:0] mOut, mMask, mCap, mRd;
   logic       mIrq;
   logic [7:0] hist[3];

   always #5 clk = ~clk;

   // External drivers on the push-pull net only where the bench enables them
   generate
      for (genvar i = 0; i < 8; i++) begin : gTbDrv
         assign ppPins[i] = tbEn[i] ? tbVal[i] : 1'bz;
      end
   endgenerate

   pullup (odPins);

   bidir_pio_edge #(
      .WIDTH(8), .OPEN_DRAIN(0), .EDGE_TYPE(EDGE_RISING), .RESET_VALUE(8'hA5)
   ) dutA (
      .clk(clk), .reset(reset), .address(address), .chipselect(csA),
      .write_n(write_n), .writedata(writedata), .readdata(rdA), .irq(irqA),
      .bidir_port(ppPins)
   );

   bidir_pio_edge #(
      .WIDTH(8), .OPEN_DRAIN(1), .EDGE_TYPE(EDGE_RISING), .RESET_VALUE(8'h00)
   ) dutB (
      .clk(clk), .reset(reset), .address(address), .chipselect(csB),
      .write_n(write_n), .writedata(writedata), .readdata(rdB), .irq(irqB),
      .bidir_port(odPins)
   );

   // Reference model: keeps the last three pin samples; the synchronised
   // value lags the pin by two samples and an edge is a rise between the
   // two oldest samples. While idle it just tracks the known pin state.
   always @(posedge clk) begin
      logic [7:0] pinNow, edgeNow, clr;
      logic       wr;
      if (!modelOn) begin
         pinNow = (initDir & initOut) | (~initDir & tbVal);
         mOut  <= initOut;
         mMask <= 8'h00;
         mCap  <= 8'h00;
         mIrq  <= 1'b0;
         mRd   <= 8'h00;
      end else begin
         pinNow  = (initDir & mOut) | (~initDir & tbVal);
         edgeNow = hist[1] & ~hist[2];
         wr      = csA & ~write_n;
         clr     = (wr && address == 3'd3) ? writedata : 8'h00;
         case (address)
            3'd0:    mRd <= hist[1];
            3'd1:    mRd <= initDir;
            3'd2:    mRd <= mMask;
            3'd3:    mRd <= mCap;
            default: mRd <= 8'h00;
         endcase
         mIrq <= |(mCap & mMask);
         mCap <= (mCap & ~clr) | edgeNow;
         if (wr) begin
            case (address)
               3'd0: mOut  <= writedata;
               3'd2: mMask <= writedata;
               3'd4: mOut  <= mOut | writedata;
               3'd5: mOut  <= mOut & ~writedata;
               default: begin end
            endcase
         end
      end
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= pinNow;
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic selA, input logic selB, input logic [2:0] a,
                                input logic w, input logic [7:0] d);
      csA       = selA;
      csB       = selB;
      address   = a;
      write_n   = ~w;
      writedata = d;
   endtask

   initial begin
      // addr, wr, wdata, chkRd, expRd, chkPin, expPin
      tblReset[0] = '{3'd0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 8'h00};
      for (int i = 1; i < 8; i++)
         tblReset[i] = '{3'(i), 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};

      tblPp[0] = '{ADDR_DIR,     1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 8'hA5};
      tblPp[1] = '{ADDR_DATA,    1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 8'h3C};
      tblPp[2] = '{ADDR_OUTSET,  1'b1, 8'h01, 1'b1, 8'h00, 1'b1, 8'h3D};
      tblPp[3] = '{ADDR_OUTCLR,  1'b1, 8'h30, 1'b1, 8'h00, 1'b1, 8'h0D};
      tblPp[4] = '{ADDR_DIR,     1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h0D};
      tblPp[5] = '{ADDR_IRQMASK, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h0D};
      tblPp[6] = '{ADDR_DATA,    1'b0, 8'h00, 1'b1, 8'h0D, 1'b1, 8'h0D};
      tblPp[7] = '{ADDR_OUTSET,  1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h0D};

      modelOn = 1'b0;
      initDir = 8'h00;
      initOut = 8'h00;
      tbEn    = 8'hFF;
      tbVal   = 8'h5A;
      reset   = 1'b1;
      applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);

      // Reset, with a DIR write presented during reset that must be ignored
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, ADDR_DIR, 1'b1, 8'hFF);
      repeat (3) tick();
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, ADDR_DATA, 1'b0, 8'h00);
      repeat (4) tick();
      checkOutput("reset irqA", {7'b0, irqA}, 8'h00);
      checkOutput("reset irqB", {7'b0, irqB}, 8'h00);

      foreach (tblReset[i]) begin
         applyStimulus(1'b1, 1'b0, tblReset[i].addr, tblReset[i].wr, tblReset[i].wdata);
         tick();
         if (tblReset[i].chkRd) checkOutput($sformatf("reset read addr%0d", i), rdA, tblReset[i].expRd);
      end

      // Push-pull output path
      tbEn = 8'h00;
      foreach (tblPp[i]) begin
         applyStimulus(1'b1, 1'b0, tblPp[i].addr, tblPp[i].wr, tblPp[i].wdata);
         tick();
         if (tblPp[i].chkRd)  checkOutput($sformatf("pp rd row%0d", i), rdA, tblPp[i].expRd);
         if (tblPp[i].chkPin) checkOutput($sformatf("pp pin row%0d", i), ppPins, tblPp[i].expPin);
      end

      // Edge capture setup: all pins inputs, driven low by the bench
      applyStimulus(1'b1, 1'b0, ADDR_DIR, 1'b1, 8'h00);
      tick();
      tbEn  = 8'hFF;
      tbVal = 8'h00;
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b0, 8'h00);
      repeat (4) tick();
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b1, 8'hFF);
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_IRQMASK, 1'b1, 8'h04);
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b0, 8'h00);
      repeat (2) tick();
      checkOutput("edge idle cap", rdA, 8'h00);
      checkOutput("edge idle irq", {7'b0, irqA}, 8'h00);

      // Rising edge on pin2 sampled at edge k
      tbVal = 8'h04;
      tick();
      tick();
      tick();
      checkOutput("cap k+2 rd", rdA, 8'h00);
      checkOutput("irq k+2", {7'b0, irqA}, 8'h00);
      tick();
      checkOutput("cap k+3 rd", rdA, 8'h04);
      checkOutput("irq k+3", {7'b0, irqA}, 8'h01);

      // Clear drops irq one cycle after the write edge
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b1, 8'h04);
      tick();
      checkOutput("irq at clear edge", {7'b0, irqA}, 8'h01);
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b0, 8'h00);
      tick();
      checkOutput("irq after clear", {7'b0, irqA}, 8'h00);
      checkOutput("cap after clear", rdA, 8'h00);

      // Same-cycle clear and new edge: set must win
      tbVal = 8'h00;
      repeat (4) tick();
      tbVal = 8'h04;
      repeat (4) tick();
      checkOutput("irq first rise", {7'b0, irqA}, 8'h01);
      tbVal = 8'h00;
      repeat (4) tick();
      tbVal = 8'h04;
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b1, 8'h04);
      tick();
      checkOutput("irq collide edge", {7'b0, irqA}, 8'h01);
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b0, 8'h00);
      tick();
      checkOutput("cap collide +1", rdA, 8'h04);
      checkOutput("irq collide +1", {7'b0, irqA}, 8'h01);
      tick();
      checkOutput("irq collide +2", {7'b0, irqA}, 8'h01);

      // Pin held high through reset must not produce a false edge
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, ADDR_DATA, 1'b0, 8'h00);
      repeat (3) tick();
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, ADDR_IRQMASK, 1'b1, 8'h04);
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput($sformatf("held-high cap c%0d", i), rdA, 8'h00);
         checkOutput($sformatf("held-high irq c%0d", i), {7'b0, irqA}, 8'h00);
      end

      // Open-drain instance with external pull-up
      applyStimulus(1'b0, 1'b1, ADDR_DIR, 1'b1, 8'h01);
      tick();
      checkOutput("od dir01 pins", odPins, 8'hFE);
      applyStimulus(1'b0, 1'b1, ADDR_DATA, 1'b1, 8'h00);
      tick();
      checkOutput("od data00 pins", odPins, 8'hFE);
      applyStimulus(1'b0, 1'b1, ADDR_DATA, 1'b1, 8'h01);
      tick();
      checkOutput("od data01 pins", odPins, 8'hFF);
      applyStimulus(1'b0, 1'b1, ADDR_DATA, 1'b0, 8'h00);
      repeat (3) tick();
      checkOutput("od data readback", rdB, 8'hFF);

      // Randomized phase against the reference model
      initDir = 8'($urandom);
      initOut = 8'($urandom);
      applyStimulus(1'b1, 1'b0, ADDR_DIR, 1'b1, initDir);
      tbEn = ~initDir;
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_DATA, 1'b1, initOut);
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_IRQMASK, 1'b1, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_DATA, 1'b0, 8'h00);
      repeat (5) tick();
      applyStimulus(1'b1, 1'b0, ADDR_EDGECAP, 1'b1, 8'hFF);
      tick();
      applyStimulus(1'b1, 1'b0, ADDR_DATA, 1'b0, 8'h00);
      repeat (2) tick();
      modelOn = 1'b1;
      for (int i = 0; i < 400; i++) begin
         csA       = ($urandom % 4) != 0;
         address   = 3'($urandom % 8);
         write_n   = 1'($urandom % 2);
         if (address == ADDR_DIR) write_n = 1'b1;
         writedata = 8'($urandom);
         tbVal     = tbVal ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         tick();
         checkOutput("rand readdata", rdA, mRd);
         checkOutput("rand irq", {7'b0, irqA}, {7'b0, mIrq});
         checkOutput("rand pins", ppPins, (initDir & mOut) | (~initDir & tbVal));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
